// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if
//   Bundles the MEM-side entry signals, the WB-side head-entry signals and
//   flush between the data-memory stage and the MEM/WB pipeline register.
//   clk/rst are not part of the bundle.
// Modports
//   master : the stage environment (drives MEM entry, flush, out_ready;
//            observes in_ready and the WB outputs)
//   slave  : the pipeline register itself
// Signals
//   flush, in_valid/in_ready, regwrite_in, memtoreg_in, load_size_in,
//   load_unsigned_in, byte_off_in, read_data_in, alu_result_in, write_reg_in,
//   out_valid/out_ready, regwrite, write_reg, wb_data
interface mem_wb_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic                  regwrite_in;
    logic                  memtoreg_in;
    logic [1:0]            load_size_in;
    logic                  load_unsigned_in;
    logic [1:0]            byte_off_in;
    logic [DATA_W-1:0]     read_data_in;
    logic [DATA_W-1:0]     alu_result_in;
    logic [REG_ADDR_W-1:0] write_reg_in;
    logic                  out_valid;
    logic                  out_ready;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     wb_data;

    modport master (
        output flush, in_valid, regwrite_in, memtoreg_in, load_size_in,
               load_unsigned_in, byte_off_in, read_data_in, alu_result_in,
               write_reg_in, out_ready,
        input  in_ready, out_valid, regwrite, write_reg, wb_data
    );

    modport slave (
        input  flush, in_valid, regwrite_in, memtoreg_in, load_size_in,
               load_unsigned_in, byte_off_in, read_data_in, alu_result_in,
               write_reg_in, out_ready,
        output in_ready, out_valid, regwrite, write_reg, wb_data
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe
//   Clocked MEM/WB pipeline register with valid/ready handshake, flush and an
//   optional 2-entry skid buffer. Load data is aligned and sign/zero extended
//   and the memtoreg mux is applied before capture, so WB sees one word.
// Parameters
//   DATA_W     datapath width (32 for sub-word loads)
//   REG_ADDR_W destination register address width
//   SKID       1 = head + skid slot, in_ready depends only on held state
//              0 = single head slot, in_ready passes out_ready through
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mem_wb_pipe_if.slave (MEM entry in, WB head entry out, flush)
module mem_wb_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SKID       = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_wb_pipe_if.slave bus
);

    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_W-1:0]     aligned;
    logic [DATA_W-1:0]     wb_in;
    logic                  in_ready_int;
    logic                  do_accept;
    logic                  do_release;

    logic                  h_valid;
    logic                  h_regwrite;
    logic [REG_ADDR_W-1:0] h_write_reg;
    logic [DATA_W-1:0]     h_data;

    logic                  s_valid;
    logic                  s_regwrite;
    logic [REG_ADDR_W-1:0] s_write_reg;
    logic [DATA_W-1:0]     s_data;

    // Load alignment and extension, then the memtoreg mux. Half loads use
    // only the upper offset bit; the low bit is ignored.
    always_comb begin
        byte_lane = bus.read_data_in[7:0];
        case (bus.byte_off_in)
            2'd0:    byte_lane = bus.read_data_in[7:0];
            2'd1:    byte_lane = bus.read_data_in[15:8];
            2'd2:    byte_lane = bus.read_data_in[23:16];
            default: byte_lane = bus.read_data_in[31:24];
        endcase
        half_lane = bus.byte_off_in[1] ? bus.read_data_in[31:16] : bus.read_data_in[15:0];
        case (bus.load_size_in)
            2'b00:   aligned = {{(DATA_W-8){!bus.load_unsigned_in & byte_lane[7]}}, byte_lane};
            2'b01:   aligned = {{(DATA_W-16){!bus.load_unsigned_in & half_lane[15]}}, half_lane};
            default: aligned = bus.read_data_in;
        endcase
        wb_in = bus.memtoreg_in ? aligned : bus.alu_result_in;
    end

    // With a skid slot, readiness only depends on whether the skid slot is
    // free, which breaks the out_ready -> in_ready combinational path.
    // Readiness is held low for the whole time reset is asserted.
    always_comb begin
        if (SKID != 0) begin
            in_ready_int = !rst && !s_valid;
        end else begin
            in_ready_int = !rst && (!h_valid || bus.out_ready);
        end
        do_accept  = bus.in_valid && in_ready_int;
        do_release = h_valid && bus.out_ready;
    end

    // Head/skid storage. Flush drops everything held plus anything accepted
    // this cycle; data fields are left stale since valid gates them.
    // When the skid slot drains into the head, no accept can happen in the
    // same cycle because in_ready was low.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid     <= 1'b0;
            h_regwrite  <= 1'b0;
            h_write_reg <= '0;
            h_data      <= '0;
            s_valid     <= 1'b0;
            s_regwrite  <= 1'b0;
            s_write_reg <= '0;
            s_data      <= '0;
        end else if (bus.flush) begin
            h_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (SKID != 0) begin
            if (do_release && s_valid) begin
                h_valid     <= 1'b1;
                h_regwrite  <= s_regwrite;
                h_write_reg <= s_write_reg;
                h_data      <= s_data;
                s_valid     <= 1'b0;
            end else if (do_accept && (!h_valid || do_release)) begin
                h_valid     <= 1'b1;
                h_regwrite  <= bus.regwrite_in;
                h_write_reg <= bus.write_reg_in;
                h_data      <= wb_in;
            end else if (do_accept) begin
                s_valid     <= 1'b1;
                s_regwrite  <= bus.regwrite_in;
                s_write_reg <= bus.write_reg_in;
                s_data      <= wb_in;
            end else if (do_release) begin
                h_valid <= 1'b0;
            end
        end else begin
            if (do_accept) begin
                h_valid     <= 1'b1;
                h_regwrite  <= bus.regwrite_in;
                h_write_reg <= bus.write_reg_in;
                h_data      <= wb_in;
            end else if (do_release) begin
                h_valid <= 1'b0;
            end
        end
    end

    // r0 is hardwired zero, so writes to it are suppressed here.
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = h_valid;
    assign bus.regwrite  = h_valid && h_regwrite && (h_write_reg != '0);
    assign bus.write_reg = h_write_reg;
    assign bus.wb_data   = h_data;

endmodule
